// File: rtl/aes_stim_gen.sv
// aes_stim_gen
// Stimulus sequencer for the AES-128 data generator. Pulls 128-bit words from
// the upstream LFSR to build (key, plaintext) pairs and offers them to the AES
// driver over a valid/ready handshake, for a programmed number of vectors.
// A one-cycle done pulse marks the end of each run.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start           run request, sampled only while idle
//   num_vec         vectors to send, latched on accepted start
//   key_hold        1 = reuse one key for the whole run, latched on start
//   abort           synchronous abort back to idle, highest priority
//   require         LFSR advance request (one word consumed per cycle high)
//   random128       LFSR output, next word visible the cycle after require
//   key, plaintext  current pair, registered
//   stim_valid      pair offered to the driver
//   stim_ready      driver accepts the pair when high with stim_valid
//   busy            high whenever not idle
//   done            one-cycle end-of-run pulse
//   sent_cnt        handshakes completed in the current or last run
module aes_stim_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             key_hold,
  input  logic             abort,
  output logic             require,
  input  logic [127:0]     random128,
  output logic [127:0]     key,
  output logic [127:0]     plaintext,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_KEY = 3'd1,
    GET_PT  = 3'd2,
    SEND    = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic             key_hold_q;
  logic             handshake;
  logic             accept_start;

  // Outputs are gated by abort so an aborted fetch never consumes an LFSR
  // word and an aborted SEND cycle is never seen as a handshake.
  always_comb begin
    require      = 1'b0;
    stim_valid   = 1'b0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    accept_start = 1'b0;
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = !abort;
          state_d      = (num_vec == '0) ? FIN : GET_KEY;
        end
      end
      GET_KEY: begin
        require = !abort;
        state_d = GET_PT;
      end
      GET_PT: begin
        require = !abort;
        state_d = SEND;
      end
      SEND: begin
        stim_valid = !abort;
        if (stim_ready) begin
          if (remaining_q == CNT_W'(1)) state_d = FIN;
          else if (key_hold_q)           state_d = GET_PT;
          else                           state_d = GET_KEY;
        end
      end
      FIN: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign handshake = stim_valid && stim_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      key_hold_q  <= 1'b0;
      sent_cnt    <= '0;
      key         <= '0;
      plaintext   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        remaining_q <= num_vec;
        key_hold_q  <= key_hold;
        sent_cnt    <= '0;
      end
      if (state_q == GET_KEY && !abort) key       <= random128;
      if (state_q == GET_PT  && !abort) plaintext <= random128;
      if (handshake) begin
        sent_cnt    <= sent_cnt + CNT_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_stim_gen.sv
module tb_aes_stim_gen;
  localparam int CNT_W = 16;
  localparam logic [127:0] POLY = 128'h87;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             key_hold;
  logic             abort;
  logic             require;
  logic [127:0]     random128;
  logic [127:0]     key;
  logic [127:0]     plaintext;
  logic             stim_valid;
  logic             stim_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  int total = 0;
  int bad   = 0;

  logic [127:0] seed;
  logic [127:0] lfsr;
  logic [127:0] exp_w;

  assign seed = 128'(64'd1234567890123456789) * 128'(64'd10000000000) * 128'(64'd10000000000)
              + 128'(64'd1234567890123456789);

  always #5 clk = ~clk;

  aes_stim_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vec    (num_vec),
    .key_hold   (key_hold),
    .abort      (abort),
    .require    (require),
    .random128  (random128),
    .key        (key),
    .plaintext  (plaintext),
    .stim_valid (stim_valid),
    .stim_ready (stim_ready),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt)
  );

  function automatic logic [127:0] lfsr_next(input logic [127:0] v);
    return v[127] ? ((v << 1) ^ POLY) : (v << 1);
  endfunction

  // Upstream LFSR stand-in: registered, advances one word per require cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr <= seed;
    else if (require) lfsr <= lfsr_next(lfsr);
  end
  assign random128 = lfsr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from an idle, post-edge position and returns observations.
  task automatic run(input int nv, input int kh, input int stall, input int abort_after,
                     output int req_c, output int val_c, output int done_at, output int done_c);
    int scnt;
    int hs;
    bit first;
    bit stable;
    bit finished;
    logic [127:0] k0, p0, ek, ep;
    req_c = 0; val_c = 0; done_at = 0; done_c = 0;
    scnt = 0; hs = 0; first = 1'b1; stable = 1'b1; finished = 1'b0;
    k0 = '0; p0 = '0; ek = '0; ep = '0;
    num_vec = CNT_W'(nv); key_hold = kh[0]; start = 1'b1;
    next_cycle();
    start = 1'b0;
    num_vec = '1;
    key_hold = ~kh[0];
    for (int c = 1; c <= 200 && !finished; c++) begin
      if (abort_after > 0 && hs == abort_after) begin
        abort = 1'b1; stim_ready = 1'b0;
        #1;
        chk("abort_cycle_require", 128'(require), 128'(0));
        next_cycle();
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_require", 128'(require), 128'(0));
        chk("abort_valid", 128'(stim_valid), 128'(0));
        chk("abort_sent_cnt", 128'(sent_cnt), 128'(abort_after));
        chk("abort_key_kept", key, ek);
        chk("abort_pt_kept", plaintext, ep);
        for (int j = 0; j < 3; j++) begin
          if (done) done_c++;
          next_cycle();
        end
        chk("abort_no_done", 128'(done_c), 128'(0));
        finished = 1'b1;
      end else begin
        stim_ready = stim_valid && (scnt >= stall);
        #1;
        if (require) req_c++;
        if (done) begin
          done_c++;
          if (done_at == 0) begin
            done_at = c;
            chk("busy_in_fin", 128'(busy), 128'(1));
          end
        end
        if (stim_valid) begin
          val_c++;
          if (scnt == 0) begin
            k0 = key; p0 = plaintext; stable = 1'b1;
          end else if (key !== k0 || plaintext !== p0) begin
            stable = 1'b0;
          end
          scnt++;
          if (stim_ready) begin
            hs++;
            if (kh == 0 || first) begin
              ek = exp_w; exp_w = lfsr_next(exp_w);
            end
            ep = exp_w; exp_w = lfsr_next(exp_w);
            first = 1'b0;
            chk("hs_key", key, ek);
            chk("hs_plaintext", plaintext, ep);
            chk("stall_stable", 128'(stable), 128'(1));
            scnt = 0;
          end
        end
        if (done_at != 0 && c == done_at + 1) begin
          chk("busy_after_done", 128'(busy), 128'(0));
          finished = 1'b1;
        end
        next_cycle();
      end
    end
    stim_ready = 1'b0;
    if (!finished) chk("run_timeout", 128'(0), 128'(1));
  endtask

  typedef struct {
    int nv;
    int kh;
    int stall;
    int exp_req;
    int exp_val;
    int exp_done_at;
  } vec_t;

  vec_t vecs[6];

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_key"}, key, '0);
    chk({tag, "_pt"}, plaintext, '0);
    chk({tag, "_sent"}, 128'(sent_cnt), '0);
    chk({tag, "_require"}, 128'(require), '0);
    chk({tag, "_valid"}, 128'(stim_valid), '0);
    chk({tag, "_busy"}, 128'(busy), '0);
    chk({tag, "_done"}, 128'(done), '0);
  endtask

  initial begin
    int rq, vl, da, dc;
    vecs[0] = '{nv: 1, kh: 0, stall: 0, exp_req: 2, exp_val: 1,  exp_done_at: 4};
    vecs[1] = '{nv: 4, kh: 1, stall: 0, exp_req: 5, exp_val: 4,  exp_done_at: 10};
    vecs[2] = '{nv: 3, kh: 0, stall: 5, exp_req: 6, exp_val: 18, exp_done_at: 25};
    vecs[3] = '{nv: 0, kh: 0, stall: 0, exp_req: 0, exp_val: 0,  exp_done_at: 1};
    vecs[4] = '{nv: 2, kh: 0, stall: 0, exp_req: 4, exp_val: 2,  exp_done_at: 7};
    vecs[5] = '{nv: 3, kh: 1, stall: 2, exp_req: 4, exp_val: 9,  exp_done_at: 14};

    rst_n = 1'b0; start = 1'b0; num_vec = '0; key_hold = 1'b0;
    abort = 1'b0; stim_ready = 1'b0;
    exp_w = '0;
    #2;
    chk_outputs_zero("reset");
    exp_w = seed;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].nv, vecs[i].kh, vecs[i].stall, 0, rq, vl, da, dc);
      chk($sformatf("v%0d_require_cycles", i), 128'(rq), 128'(vecs[i].exp_req));
      chk($sformatf("v%0d_valid_cycles", i), 128'(vl), 128'(vecs[i].exp_val));
      chk($sformatf("v%0d_done_cycle", i), 128'(da), 128'(vecs[i].exp_done_at));
      chk($sformatf("v%0d_done_pulses", i), 128'(dc), 128'(1));
      chk($sformatf("v%0d_sent_cnt", i), 128'(sent_cnt), 128'(vecs[i].nv));
      if (i == 0) begin
        chk("first_key_seed", key, seed);
        chk("first_pt_seed_x2", plaintext, seed << 1);
      end
    end

    // Abort while fetching the third key, then a clean run afterwards.
    run(10, 0, 0, 2, rq, vl, da, dc);
    chk("abort_run_require", 128'(rq), 128'(4));
    run(1, 0, 0, 0, rq, vl, da, dc);
    chk("post_abort_sent_cnt", 128'(sent_cnt), 128'(1));
    chk("post_abort_done_cycle", 128'(da), 128'(4));

    // Asynchronous reset in the middle of SEND.
    num_vec = CNT_W'(5); key_hold = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int j = 0; j < 8 && !stim_valid; j++) next_cycle();
    chk("pre_reset_valid", 128'(stim_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrun_reset");
    exp_w = seed;
    #2;
    rst_n = 1'b1;
    next_cycle();
    run(1, 0, 0, 0, rq, vl, da, dc);
    chk("after_reset_done_cycle", 128'(da), 128'(4));
    chk("after_reset_require", 128'(rq), 128'(2));
    chk("after_reset_sent", 128'(sent_cnt), 128'(1));
    chk("after_reset_key", key, seed);
    chk("after_reset_pt", plaintext, seed << 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes_stim_gen.md
# aes_stim_gen

Stimulus sequencer for the AES-128 verification platform's data generator. It sits directly downstream of the 128-bit LFSR. It pulls random words to form (key, plaintext) pairs and presents them to the AES DUT driver over a valid/ready handshake, for a programmed number of vectors. A one-cycle done pulse marks the end of each run.

## Interface
- CNT_W, default 16: width of the vector-count input and the sent counter.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- num_vec  in  CNT_W  vectors to send; latched on accepted start.
- key_hold  in  1  latched on accepted start; 1 = one key for the whole run, fresh plaintext per vector.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- require  out  1  LFSR advance request; combinational, high in GET_KEY/GET_PT only.
- random128  in  128  LFSR output; registered upstream, next value visible the cycle after require.
- key  out  128  current key; registered.
- plaintext  out  128  current plaintext; registered.
- stim_valid  out  1  key/plaintext pair offered to the DUT driver.
- stim_ready  in  1  DUT driver accepts the pair when high together with stim_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in FIN.
- sent_cnt  out  CNT_W  handshakes completed in the current or last run.

## Operation
- States: IDLE, GET_KEY, GET_PT, SEND, FIN.
- Reset: state IDLE. key, plaintext, sent_cnt, remaining count and latched key_hold are all 0. require, stim_valid, busy and done are all 0.
- IDLE + start: latch num_vec into remaining and latch key_hold. Clear sent_cnt.
  - If num_vec==0, go to FIN. No require is issued and no valid is offered.
  - Otherwise go to GET_KEY.
- GET_KEY (1 cycle): require=1, key<=random128, go to GET_PT.
- GET_PT (1 cycle): require=1, plaintext<=random128, go to SEND.
- SEND: stim_valid=1. key and plaintext are held stable until the handshake.
- On stim_valid&&stim_ready: sent_cnt+1, remaining-1, then:
  - If remaining was 1, go to FIN.
  - Else if latched key_hold=1, go to GET_PT.
  - Else go to GET_KEY.
- FIN (1 cycle): done=1, then go to IDLE.
- start is ignored outside IDLE. num_vec and key_hold changes mid-run have no effect.
- abort has priority over every other transition.
  - Next state is IDLE and no done pulse is issued.
  - sent_cnt keeps its value; key and plaintext keep their values.
  - require is not asserted in the abort cycle's successor.
- Each require consumes exactly one LFSR word. No word is fetched and then discarded.
- sent_cnt is CNT_W-bit unsigned. It cannot overflow because it is bounded by num_vec ≤ 2^CNT_W−1.

## Timing
- start accepted at edge 0:
  - GET_KEY in cycle 1.
  - GET_PT in cycle 2.
  - stim_valid high from cycle 3, with key and plaintext valid in that same cycle.
- Handshake at cycle t:
  - Next stim_valid at t+3 (fresh key) or t+2 (key_hold=1).
  - After the last vector, done is high in cycle t+1 and busy is low from t+2.
- num_vec==0: done in cycle 1 and busy high only in cycle 1.
- stim_ready held high gives throughput of one vector per 3 cycles (per 2 cycles with key_hold).
- stim_valid, once high, stays high until the handshake, except on abort or reset.
- Reset asserted mid-run forces all outputs to their reset values immediately (asynchronous). No done pulse is issued.

## Test plan
- LFSR at its reset seed, start with num_vec=1, key_hold=0, stim_ready=1 → require high in cycles 1–2; stim_valid in cycle 3 only; done in cycle 4; sent_cnt=1.
  - key=123456789012345678901234567890123456789.
  - plaintext=246913578024691357802469135780246913578 (seed bit 127 is 0, so one shift is ×2).
- num_vec=4, key_hold=1, stim_ready=1 → require high for 5 cycles total; one key value across all 4 handshakes; 4 distinct plaintexts; done 1 cycle after the 4th handshake; sent_cnt=4.
- num_vec=3 with stim_ready low for 5 cycles in each SEND → stim_valid, key and plaintext stable throughout each stall; no extra require; sent_cnt=3.
- num_vec=0 → done in cycle 1; require and stim_valid never high; sent_cnt=0.
- num_vec=10, abort after the 2nd handshake while in GET_KEY → IDLE next cycle; no done pulse; sent_cnt=2; a new start then runs normally with sent_cnt cleared.
- rst_n low during SEND of a 5-vector run → all outputs 0 immediately; after release, start with num_vec=1 behaves as in the first scenario, given the LFSR is also reset.
